// File: rtl/minv_reg_seq.sv
// minv_reg_seq: command sequencer driving the slice controls of the 256-bit inverse operand register
module minv_reg_seq #(
   parameter int NWORDS = 8,
   parameter int WIDTH  = 32,
   parameter int CNT_W  = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic             cmd_fill,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic [WIDTH-1:0] reg_lsw,
   output logic [WIDTH-1:0] reg_din,
   output logic             reg_we,
   output logic             reg_sel_cyc,
   output logic             reg_sel_rs,
   output logic             reg_clr,
   output logic             reg_bit256,
   output logic             done
);
   localparam int BITS = NWORDS * WIDTH;
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHR, READ} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, shr_cnt;
   logic fill, done_i, ld_beat, rd_beat, shr_act;
   assign shr_cnt     = (cmd_cnt > CNT_W'(BITS)) ? CNT_W'(BITS) : cmd_cnt;
   assign cmd_ready   = !rst && state == IDLE;
   assign in_ready    = !rst && state == LOAD;
   assign out_valid   = !rst && state == READ;
   assign ld_beat     = in_ready && in_valid;
   assign rd_beat     = out_valid && out_ready;
   assign shr_act     = !rst && state == SHR && cnt != '0;
   assign reg_we      = ld_beat || rd_beat || shr_act;
   assign reg_sel_cyc = rd_beat;
   assign reg_sel_rs  = shr_act;
   assign reg_clr     = rst || state == CLEAR;
   assign reg_bit256  = !rst && state == SHR && fill;
   assign reg_din     = in_ready ? in_data : '0;
   assign out_data    = out_valid ? reg_lsw : '0;
   assign done        = !rst && done_i;
   // next state, counter and done pulse
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_i   = 1'b0;
      case (state)
         IDLE: if (cmd_valid) begin
            state_nx = cmd_op == 2'b00 ? CLEAR : cmd_op == 2'b01 ? LOAD : cmd_op == 2'b10 ? SHR : READ;
            cnt_nx   = cmd_op == 2'b10 ? shr_cnt : CNT_W'(NWORDS);
         end
         CLEAR: begin
            done_i   = 1'b1;
            state_nx = IDLE;
         end
         SHR: begin
            done_i   = cnt <= CNT_W'(1);
            state_nx = done_i ? IDLE : SHR;
            cnt_nx   = cnt == '0 ? '0 : cnt - 1'b1;
         end
         LOAD, READ: if (state == LOAD ? in_valid : out_ready) begin
            done_i   = cnt == CNT_W'(1);
            state_nx = done_i ? IDLE : state;
            cnt_nx   = cnt - 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end
   // state, counter and latched fill bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         fill  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == IDLE && cmd_valid) fill <= cmd_fill;
      end
   end
endmodule

// File: tb/tb_minv_reg_seq.sv
// tb_minv_reg_seq: randomized self-checking bench with a behavioural register bank and reference model
module tb_minv_reg_seq;
   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready, cmd_fill = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [8:0] cmd_cnt = '0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [31:0] in_data = '0, out_data, reg_lsw, reg_din;
   logic reg_we, reg_sel_cyc, reg_sel_rs, reg_clr, reg_bit256, done;
   logic [255:0] bank = {8{32'hdead_beef}};
   logic [255:0] mdl = '0;
   int n_chk = 0, n_pass = 0;

   minv_reg_seq dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .reg_lsw(reg_lsw), .reg_din(reg_din), .reg_we(reg_we), .reg_sel_cyc(reg_sel_cyc),
      .reg_sel_rs(reg_sel_rs), .reg_clr(reg_clr), .reg_bit256(reg_bit256), .done(done)
   );

   always #5 clk = ~clk;

   // the eight-slice register bank driven by the sequencer
   always @(posedge clk) begin
      if (reg_clr) bank <= '0;
      else if (reg_we) bank <= reg_sel_rs ? {reg_bit256, bank[255:1]} :
                               reg_sel_cyc ? {bank[31:0], bank[255:32]} : {reg_din, bank[255:32]};
   end
   assign reg_lsw = bank[31:0];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got %h exp %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [8:0] n, input logic f);
      cmd_valid = 1'b1; cmd_op = op; cmd_cnt = n; cmd_fill = f;
      #1;
      chk("cmd_ready", 256'(cmd_ready), 256'(1));
      chk("accept_quiet", 256'({done, reg_we, reg_clr}), 256'(0));
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = '0; cmd_fill = 1'b0;
   endtask

   task automatic do_load(input logic [255:0] words, input int mode);
      int beats = 0, cyc = 0;
      bit bad = 0, seen = 0;
      send_cmd(2'b01, 9'd0, 1'b0);
      while (cyc < 200 && !seen) begin
         in_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         in_data = in_valid ? words[32*beats +: 32] : $urandom;
         #1;
         if (!in_ready || out_valid || reg_din !== in_data) bad = 1;
         if (reg_we !== in_valid || reg_sel_cyc || reg_sel_rs || reg_clr) bad = 1;
         if (in_valid) beats++;
         if (done !== (in_valid && beats == 8)) bad = 1;
         seen = done;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      mdl = words;
      chk("ld_done", 256'(seen), 256'(1));
      chk("ld_beats", 256'(beats), 256'(8));
      chk("ld_enc", 256'(bad), 256'(0));
      if (mode < 2) chk("ld_cycles", 256'(cyc), mode == 0 ? 256'(8) : 256'(15));
      chk("ld_bank", bank, mdl);
   endtask

   task automatic do_read(input bit stall);
      int beats = 0, cyc = 0;
      bit bad = 0, bad_d = 0, seen = 0;
      send_cmd(2'b11, 9'd0, 1'b0);
      while (cyc < 200 && !seen) begin
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = 1'($urandom_range(0, 1));
         #1;
         if (!out_valid || in_ready || reg_din !== 32'h0) bad = 1;
         if (reg_we !== out_ready || reg_sel_cyc !== out_ready || reg_sel_rs || reg_clr) bad = 1;
         if (out_ready) begin
            if (beats < 8 && out_data !== mdl[32*beats +: 32]) bad_d = 1;
            beats++;
         end
         if (done !== (out_ready && beats == 8)) bad = 1;
         seen = done;
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b0; in_valid = 1'b0;
      chk("rd_done", 256'(seen), 256'(1));
      chk("rd_beats", 256'(beats), 256'(8));
      chk("rd_enc", 256'(bad), 256'(0));
      chk("rd_data", 256'(bad_d), 256'(0));
      chk("rd_bank", bank, mdl);
   endtask

   task automatic do_shr(input logic [8:0] n, input logic f);
      int k = n > 256 ? 256 : int'(n);
      int len = k == 0 ? 1 : k;
      int cyc = 0, nsr = 0;
      bit bad = 0, seen = 0;
      send_cmd(2'b10, n, f);
      while (cyc < 400 && !seen) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (in_ready || out_valid || out_data !== 32'h0 || reg_din !== 32'h0) bad = 1;
         if (reg_sel_cyc || reg_clr || reg_bit256 !== f) bad = 1;
         if (reg_we !== (k != 0) || reg_sel_rs !== (k != 0)) bad = 1;
         if (reg_we && reg_sel_rs) nsr++;
         if (done !== (cyc == len - 1)) bad = 1;
         seen = done;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      mdl = k == 256 ? {256{f}} : (mdl >> k) | (f ? ~({256{1'b1}} >> k) : 256'h0);
      chk("shr_done", 256'(seen), 256'(1));
      chk("shr_cycles", 256'(cyc), 256'(len));
      chk("shr_steps", 256'(nsr), 256'(k));
      chk("shr_enc", 256'(bad), 256'(0));
      chk("shr_bank", bank, mdl);
   endtask

   task automatic do_clear();
      send_cmd(2'b00, 9'd0, 1'b0);
      #1;
      chk("clr_ctl", 256'({reg_clr, done, reg_we}), 256'(3'b110));
      @(negedge clk);
      mdl = '0;
      chk("clr_bank", bank, mdl);
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [255:0] w;
      int nclr, ndone;
      repeat (3) begin
         @(negedge clk); #1;
         chk("rst_ctl", 256'({reg_clr, cmd_ready, done, reg_we, in_ready, out_valid}), 256'(6'b100000));
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rdy", 256'(cmd_ready), 256'(1));
      chk("rst_bank", bank, 256'h0);
      @(negedge clk);
      for (int i = 0; i < 8; i++) w[32*i +: 32] = 32'(i + 1);
      do_load(w, 0);
      do_read(1'b0);
      do_load(rnd256(), 1);
      do_clear();
      w = 256'h8;
      do_load(w, 2);
      do_shr(9'd3, 1'b1);
      chk("shr3_const", bank, {32'he000_0000, 192'h0, 32'h1});
      do_load(rnd256(), 0);
      do_shr(9'd300, 1'b0);
      do_load(rnd256(), 2);
      do_shr(9'd0, 1'b1);
      do_shr(9'd256, 1'b1);
      for (int r = 0; r < 14; r++) begin
         case ($urandom_range(0, 3))
            0: do_clear();
            1: do_load(rnd256(), 2);
            2: do_shr(9'($urandom_range(0, 300)), 1'($urandom_range(0, 1)));
            default: do_read(1'b1);
         endcase
      end
      do_load(rnd256(), 0);
      rst = 1'b1; nclr = 0; ndone = 0;
      repeat (3) begin
         #1;
         nclr += int'(reg_clr); ndone += int'(done);
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      chk("rst_load_clr", 256'(nclr), 256'(3));
      chk("rst_load_done", 256'(ndone), 256'(0));
      chk("rst_load_rdy", 256'(cmd_ready), 256'(1));
      chk("rst_load_bank", bank, 256'h0);
      @(negedge clk);
      do_load(rnd256(), 0);
      send_cmd(2'b11, 9'd0, 1'b0);
      out_ready = 1'b1;
      repeat (3) begin #1; @(negedge clk); end
      rst = 1'b1;
      #1;
      chk("rst_rd_ctl", 256'({out_valid, done, reg_we, reg_clr}), 256'(4'b0001));
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_rd_rdy", 256'(cmd_ready), 256'(1));
      chk("rst_rd_bank", bank, 256'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
